// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and default widths for the two-master Wishbone arbiter
package wb_arb_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   adr;
    logic [DEF_DATA_W-1:0]   dat;
    logic [DEF_DATA_W/8-1:0] sel;
    logic                    we;
  } t_wb_req;
endpackage

// File: rtl/wb_arb_timer.sv
// wb_arb_timer: counts cycles while enabled and flags the last cycle before timeout
module wb_arb_timer #(
  parameter int TIMEOUT = 255,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expire_o = en_i & (cnt_q == TW'(TIMEOUT - 1));
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_rr_arbiter2.sv
// wb_rr_arbiter2: round-robin arbiter serialising two pipelined Wishbone masters onto one slave,
// one transaction at a time, with a timeout that answers a silent slave with err.
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic              grant_o
);
  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } req_t;
  arb_state_t state_q, state_d;
  req_t req_q, req_d;
  logic last_q, last_d, grant_q, grant_d;
  logic ack0_q, ack0_d, err0_q, err0_d, ack1_q, ack1_d, err1_q, err1_d;
  logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic req0, req1, pick, go, own_cyc, rsp, expire, busy;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign busy = state_q != ARB_IDLE;
  // Stall must read 1 while reset is held, even if a master is requesting.
  assign go = rst_n_i & !busy & (req0 | req1);
  assign pick = (req0 & req1) ? ~last_q : req1;
  assign own_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
  assign rsp = (state_q == ARB_WAIT) & (s_ack_i | s_err_i);
  wb_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (!busy),
    .en_i    (busy),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    last_d = last_q;
    grant_d = grant_q;
    ack0_d = 1'b0;
    err0_d = 1'b0;
    ack1_d = 1'b0;
    err1_d = 1'b0;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    if (go) begin
      state_d = ARB_REQ;
      grant_d = pick;
      req_d.adr = pick ? m1_adr_i : m0_adr_i;
      req_d.dat = pick ? m1_dat_i : m0_dat_i;
      req_d.sel = pick ? m1_sel_i : m0_sel_i;
      req_d.we = pick ? m1_we_i : m0_we_i;
    end else if (busy) begin
      if (!own_cyc) begin
        state_d = ARB_IDLE;
        last_d = grant_q;
      end else if (rsp | expire) begin
        state_d = ARB_IDLE;
        last_d = grant_q;
        ack0_d = !grant_q & rsp & !s_err_i;
        ack1_d = grant_q & rsp & !s_err_i;
        err0_d = !grant_q & (rsp ? s_err_i : 1'b1);
        err1_d = grant_q & (rsp ? s_err_i : 1'b1);
        dat0_d = (rsp & !grant_q) ? s_dat_i : dat0_q;
        dat1_d = (rsp & grant_q) ? s_dat_i : dat1_q;
      end else if (state_q == ARB_REQ && !s_stall_i) state_d = ARB_WAIT;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      req_q <= '0;
      last_q <= 1'b1;
      grant_q <= 1'b0;
      ack0_q <= 1'b0;
      err0_q <= 1'b0;
      ack1_q <= 1'b0;
      err1_q <= 1'b0;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      last_q <= last_d;
      grant_q <= grant_d;
      ack0_q <= ack0_d;
      err0_q <= err0_d;
      ack1_q <= ack1_d;
      err1_q <= err1_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
    end
  assign m0_stall_o = !(go & !pick);
  assign m1_stall_o = !(go & pick);
  assign m0_ack_o = ack0_q;
  assign m0_err_o = err0_q;
  assign m0_dat_o = dat0_q;
  assign m1_ack_o = ack1_q;
  assign m1_err_o = err1_q;
  assign m1_dat_o = dat1_q;
  assign s_cyc_o = busy;
  assign s_stb_o = state_q == ARB_REQ;
  assign s_we_o = req_q.we;
  assign s_adr_o = req_q.adr;
  assign s_sel_o = req_q.sel;
  assign s_dat_o = req_q.dat;
  assign grant_o = grant_q;
endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// tb_wb_rr_arbiter2: vector table, directed corner sequences and a randomized
// transaction-level scoreboard for the two-master round-robin arbiter.
module tb_wb_rr_arbiter2;
  logic clk = 1'b0, rst_n_i = 1'b0;
  logic [1:0] m_cyc, m_stb, m_we;
  logic [3:0] m_adr [2];
  logic [3:0] m_sel [2];
  logic [31:0] m_dat [2];
  logic [1:0] m_ack, m_err, m_stall;
  logic [31:0] m_rdat [2];
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_stall_i, grant_o;
  logic [3:0] s_adr_o, s_sel_o;
  logic [31:0] s_dat_o, s_dat_i;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  wb_rr_arbiter2 #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
    .m0_sel_i(m_sel[0]), .m0_dat_i(m_dat[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m0_stall_o(m_stall[0]), .m0_dat_o(m_rdat[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
    .m1_sel_i(m_sel[1]), .m1_dat_i(m_dat[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .m1_stall_o(m_stall[1]), .m1_dat_o(m_rdat[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_stall_i(s_stall_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );
  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic [1:0] stall;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n_i = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] errs;
    logic [1:0] r;
    logic win, mdl_last, rsp_v, rsp_m, rsp_err, cap, sl_acc, e_we;
    logic [3:0] e_adr, e_sel;
    logic [31:0] e_dat;
    logic [31:0] exp_dat [2];
    int owner, sl_lat, sl_stalls, i0, i1;
    logic eg;
    tbl[0] = '{2'b00, 2'b00, 2'b11};
    tbl[1] = '{2'b01, 2'b01, 2'b10};
    tbl[2] = '{2'b10, 2'b10, 2'b01};
    tbl[3] = '{2'b11, 2'b11, 2'b10};
    tbl[4] = '{2'b11, 2'b00, 2'b11};
    tbl[5] = '{2'b00, 2'b11, 2'b11};
    tbl[6] = '{2'b01, 2'b10, 2'b11};
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int x = 0; x < 2; x++) begin
      m_adr[x] = '0; m_sel[x] = 4'hF; m_dat[x] = '0;
    end
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0; s_dat_i = '0;
    do_reset();
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_stall", m_stall, 2'b11);
    chk("rst_ack_err", {m_ack, m_err}, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_sfields", {s_we_o, s_adr_o, s_sel_o, s_dat_o}, 0);
    chk("rst_rdat", m_rdat[0] | m_rdat[1], 0);
    // reset asserted in the middle of a strobe
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 4'h4;
    tick();
    chk("rstmid_pre_stb", s_stb_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rstmid_cyc", s_cyc_o, 0);
    chk("rstmid_stall", m_stall, 2'b11);
    m_cyc = '0; m_stb = '0;
    tick();
    rst_n_i = 1'b1;
    errs = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      errs[k] = |{m_ack, m_err, s_cyc_o};
    end
    chk("rstmid_quiet", errs, 0);
    // idle arbitration table, last_grant=1 after reset
    do_reset();
    foreach (tbl[i]) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      #1;
      chk($sformatf("tbl_stall[%0d]", i), m_stall, tbl[i].stall);
      m_cyc = '0; m_stb = '0;
      tick();
    end
    // single read, slave acks 2 cycles after strobe
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_adr[0] = 4'h4;
    tick();
    m_stb[0] = 0;
    chk("rd_stb", s_stb_o, 1);
    chk("rd_adr_we_g", {s_adr_o, s_we_o, grant_o}, {4'h4, 1'b0, 1'b0});
    tick();
    chk("rd_wait", {s_cyc_o, s_stb_o}, 2'b10);
    tick();
    s_ack_i = 1; s_dat_i = 32'hCAFE0001;
    chk("rd_no_early_ack", m_ack, 0);
    tick();
    s_ack_i = 0;
    chk("rd_ack", m_ack, 2'b01);
    chk("rd_dat", m_rdat[0], 32'hCAFE0001);
    chk("rd_cyc_drop", s_cyc_o, 0);
    m_cyc[0] = 0;
    tick();
    chk("rd_ack_pulse", m_ack, 0);
    // contention: 4 writes each, alternating grants
    do_reset();
    i0 = 0; i1 = 0; eg = 0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11;
    m_dat[0] = 32'hA0000000; m_dat[1] = 32'hB0000000;
    for (int t = 0; t < 8; t++) begin
      #1;
      chk("cont_stall", m_stall, eg ? 2'b01 : 2'b10);
      tick();
      chk("cont_grant", grant_o, eg);
      chk("cont_sdat", s_dat_o, eg ? (32'hB0000000 | i1) : (32'hA0000000 | i0));
      if (eg) begin
        i1++;
        if (i1 == 4) m_stb[1] = 0; else m_dat[1] = 32'hB0000000 | i1;
      end else begin
        i0++;
        if (i0 == 4) m_stb[0] = 0; else m_dat[0] = 32'hA0000000 | i0;
      end
      tick();
      s_ack_i = 1;
      tick();
      s_ack_i = 0;
      chk("cont_ack", m_ack, eg ? 2'b10 : 2'b01);
      if (i0 == 4) m_cyc[0] = 0;
      if (i1 == 4) m_cyc[1] = 0;
      eg = !eg;
    end
    // timeout: slave never answers
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0; m_adr[1] = 4'h8;
    tick();
    m_stb[1] = 0;
    chk("to_stb", s_stb_o, 1);
    errs = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      errs[k-1] = m_err[1];
    end
    chk("to_err_at_8", errs, 8'h80);
    chk("to_cyc", s_cyc_o, 0);
    chk("to_no_ack", m_ack, 0);
    m_cyc[1] = 0;
    tick();
    chk("to_err_pulse", m_err, 0);
    // ack arriving on the timeout cycle
    m_cyc[0] = 1; m_stb[0] = 1;
    tick();
    m_stb[0] = 0;
    for (int k = 1; k <= 7; k++) tick();
    s_ack_i = 1; s_dat_i = 32'h0000BEEF;
    tick();
    s_ack_i = 0;
    chk("toack_ack_err", {m_ack[0], m_err[0]}, 2'b10);
    m_cyc[0] = 0;
    tick();
    // ack and err together
    m_cyc[0] = 1; m_stb[0] = 1;
    tick();
    m_stb[0] = 0;
    tick();
    s_ack_i = 1; s_err_i = 1; s_dat_i = 32'h00001234;
    tick();
    s_ack_i = 0; s_err_i = 0;
    chk("ackerr_ack_err", {m_ack[0], m_err[0]}, 2'b01);
    chk("ackerr_dat", m_rdat[0], 32'h00001234);
    m_cyc[0] = 0;
    tick();
    // abort in WAIT with m0 pending
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    m_stb[1] = 0;
    tick();
    chk("ab_wait", {s_cyc_o, s_stb_o}, 2'b10);
    m_cyc[1] = 0; m_cyc[0] = 1; m_stb[0] = 1; m_dat[0] = 32'h5A5A5A5A;
    tick();
    chk("ab_cyc_drop", s_cyc_o, 0);
    s_ack_i = 1;
    #1;
    chk("ab_m0_wins", m_stall, 2'b10);
    tick();
    s_ack_i = 0; m_stb[0] = 0;
    chk("ab_no_resp", {m_ack, m_err}, 0);
    chk("ab_next", {s_stb_o, grant_o, s_dat_o}, {1'b1, 1'b0, 32'h5A5A5A5A});
    tick();
    s_ack_i = 1;
    tick();
    s_ack_i = 0;
    chk("ab_m0_ack", m_ack, 2'b01);
    m_cyc[0] = 0;
    // randomized traffic against a transaction-level model
    do_reset();
    owner = -1; mdl_last = 1; rsp_v = 0; rsp_m = 0; rsp_err = 0; cap = 0; sl_acc = 0;
    sl_lat = 0; sl_stalls = 0; exp_dat[0] = '0; exp_dat[1] = '0;
    e_adr = '0; e_sel = '0; e_dat = '0; e_we = 0;
    for (int n = 0; n < 2000; n++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        chk("rnd_ack", m_ack[x], rsp_v && rsp_m == x && !rsp_err);
        chk("rnd_err", m_err[x], rsp_v && rsp_m == x && rsp_err);
        chk("rnd_rdat", m_rdat[x], exp_dat[x]);
      end
      if (rsp_v) begin
        m_cyc[rsp_m] = 0; owner = -1; mdl_last = rsp_m; rsp_v = 0;
      end
      if (cap) begin
        m_stb[owner] = 0; cap = 0;
      end
      s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
      chk("rnd_cyc", s_cyc_o, owner >= 0);
      if (owner < 0) begin
        s_ack_i = $urandom_range(3) == 0;
        s_err_i = $urandom_range(3) == 0;
      end else if (!sl_acc) begin
        chk("rnd_stb", s_stb_o, 1);
        chk("rnd_req", {s_adr_o, s_sel_o, s_we_o, grant_o}, {e_adr, e_sel, e_we, owner[0]});
        chk("rnd_sdat", s_dat_o, e_dat);
        s_stall_i = (sl_stalls < 2) && ($urandom_range(2) == 0);
        if (s_stall_i) sl_stalls++;
        else begin
          sl_acc = 1; sl_lat = $urandom_range(3);
        end
      end else begin
        chk("rnd_wait_stb", s_stb_o, 0);
        if (sl_lat == 0) begin
          s_err_i = $urandom_range(7) == 0;
          s_ack_i = !s_err_i || ($urandom_range(1) == 1);
          s_dat_i = $urandom;
          rsp_v = 1; rsp_m = owner[0]; rsp_err = s_err_i; exp_dat[owner] = s_dat_i;
          sl_acc = 0;
        end else sl_lat--;
      end
      for (int x = 0; x < 2; x++)
        if (!m_cyc[x] && $urandom_range(2) == 0) begin
          m_cyc[x] = 1; m_stb[x] = 1; m_we[x] = 1'($urandom);
          m_adr[x] = 4'($urandom); m_sel[x] = 4'($urandom); m_dat[x] = $urandom;
        end
      #1;
      r = m_cyc & m_stb;
      if (owner < 0 && r != 0) begin
        win = (r == 2'b11) ? !mdl_last : r[1];
        chk("rnd_stall", m_stall, win ? 2'b01 : 2'b10);
        owner = int'(win); cap = 1; sl_stalls = 0;
        e_adr = m_adr[win]; e_sel = m_sel[win]; e_dat = m_dat[win]; e_we = m_we[win];
      end else chk("rnd_stall_idle", m_stall, 2'b11);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
